timer_ctrl: RTL and testbench

Control and epoch stage that sits directly downstream of the 4-bit Gray timer counter. It generates the counter's count-enable (cten) from a clock prescaler and drives the counter's synchronous clear request. It consumes the counter's Gray value and terminal-count pulse, and extends the count with an 8-bit epoch register to a 12-bit binary elapsed value. It compares elapsed time against a programmable match value and raises done/irq in one-shot or periodic mode.

---
 rtl/timer_ctrl.sv | 133 +++++++++++++
 tb/tb_timer_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Prescaled count-enable, clear sequencing and epoch extension for the 4-bit Gray counter stage.
// Match raises irq one cycle after elapsed==match_val; no backpressure, start/stop/pause are sampled every cycle.
module timer_ctrl #(
  parameter int PRESCALE = 10,
  parameter int EPOCH_W  = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               periodic,
  input  logic [EPOCH_W+3:0] match_val,
  input  logic [3:0]         cnt_gray,
  input  logic               cnt_tc,
  output logic               cten,
  output logic               cnt_clr_b,
  output logic [EPOCH_W+3:0] elapsed,
  output logic               busy,
  output logic               done,
  output logic               irq
);

  localparam int DIV_W = $clog2(PRESCALE);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div;
  logic [EPOCH_W-1:0] epoch;
  logic [3:0]         cnt_bin;
  logic               match;

  assign cnt_bin[3] = cnt_gray[3];
  assign cnt_bin[2] = ^cnt_gray[3:2];
  assign cnt_bin[1] = ^cnt_gray[3:1];
  assign cnt_bin[0] = ^cnt_gray[3:0];

  assign elapsed = {epoch, cnt_bin};
  assign match   = (elapsed == match_val);

  // Decoded from state/div flops only, so the counter sees a glitch-free enable.
  assign cten = (state == S_RUN) && (div == DIV_MAX);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_IDLE;
      div       <= '0;
      epoch     <= '0;
      cnt_clr_b <= 1'b1;
      irq       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      irq       <= 1'b0;
      cnt_clr_b <= 1'b1;
      // Track the counter wrap on the same edge it returns to 0000.
      if (cten && cnt_tc) begin
        epoch <= epoch + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLEAR;
            cnt_clr_b <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_CLEAR: begin
          div   <= '0;
          epoch <= '0;
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          div <= (div == DIV_MAX) ? '0 : div + 1'b1;
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (match) begin
            irq <= 1'b1;
            if (periodic) begin
              state     <= S_CLEAR;
              cnt_clr_b <= 1'b0;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (pause) begin
            state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (!pause) begin
            state <= S_RUN;
          end
        end
        S_DONE: begin
          if (stop) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state     <= S_CLEAR;
            cnt_clr_b <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: two instances (PRESCALE 4 and 2) each driving a behavioural Gray counter.
module tb_timer_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic        start4, start2, stop, pause, periodic;
  logic [11:0] match_val;
  logic [3:0]  g4, g2;
  logic        tc4, tc2;
  logic        cten4, clrb4, busy4, done4, irq4;
  logic        cten2, clrb2, busy2, done2, irq2;
  logic [11:0] el4, el2;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic [11:0] el;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  exp_t e4, e2;

  timer_ctrl #(.PRESCALE(4), .EPOCH_W(8)) u_dut4 (
    .clk(clk), .clr(clr), .start(start4), .stop(stop), .pause(pause),
    .periodic(periodic), .match_val(match_val), .cnt_gray(g4), .cnt_tc(tc4),
    .cten(cten4), .cnt_clr_b(clrb4), .elapsed(el4), .busy(busy4),
    .done(done4), .irq(irq4)
  );

  timer_ctrl #(.PRESCALE(2), .EPOCH_W(8)) u_dut2 (
    .clk(clk), .clr(clr), .start(start2), .stop(stop), .pause(pause),
    .periodic(periodic), .match_val(match_val), .cnt_gray(g2), .cnt_tc(tc2),
    .cten(cten2), .cnt_clr_b(clrb2), .elapsed(el2), .busy(busy2),
    .done(done2), .irq(irq2)
  );

  function automatic logic [3:0] gray_to_bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [3:0] bin_to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)        g4 <= 4'b0000;
    else if (!clrb4) g4 <= 4'b0000;
    else if (cten4)  g4 <= bin_to_gray(gray_to_bin(g4) + 4'd1);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)        g2 <= 4'b0000;
    else if (!clrb2) g2 <= 4'b0000;
    else if (cten2)  g2 <= bin_to_gray(gray_to_bin(g2) + 4'd1);
  end

  assign tc4 = cten4 && (g4 == 4'b1000);
  assign tc2 = cten2 && (g2 == 4'b1000);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_irq(input bit on_dut2, input int at, input logic [11:0] v);
    exp_t e;
    e.cyc = at;
    e.el  = v;
    if (on_dut2) q2.push_back(e);
    else         q4.push_back(e);
  endtask

  // Scoreboard: every irq pulse must match the next expected (cycle, elapsed) entry.
  always @(negedge clk) begin
    if (clr && irq4) begin
      if (q4.size() == 0) begin
        check("irq4_unexpected", 32'(irq4), 32'd0);
      end else begin
        e4 = q4.pop_front();
        check("irq4_cycle", 32'(cyc), 32'(e4.cyc));
        check("irq4_elapsed", 32'(el4), 32'(e4.el));
      end
    end
    if (clr && irq2) begin
      if (q2.size() == 0) begin
        check("irq2_unexpected", 32'(irq2), 32'd0);
      end else begin
        e2 = q2.pop_front();
        check("irq2_cycle", 32'(cyc), 32'(e2.cyc));
        check("irq2_elapsed", 32'(el2), 32'(e2.el));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    start4 = 1'b0; start2 = 1'b0; stop = 1'b0; pause = 1'b0;
    periodic = 1'b0; match_val = 12'h000;
    #2 clr = 1'b0;
    #2;
    check("reset_outs4", 32'({cten4, clrb4, busy4, done4, irq4}), 32'h08);
    check("reset_outs2", 32'({cten2, clrb2, busy2, done2, irq2}), 32'h08);
    check("reset_el4", 32'(el4), 32'h000);
    tick(2);
    clr = 1'b1;
    tick(2);
    check("idle4", 32'({busy4, cten4, clrb4}), 32'h1);

    // Reset in the middle of a run.
    match_val = 12'hFFF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 200 && el2 != 12'h025; i++) tick();
    check("t1_reach_025", 32'(el2), 32'h025);
    check("t1_busy", 32'(busy2), 32'd1);
    #2 clr = 1'b0;
    #1;
    check("t1_rst_outs", 32'({cten2, clrb2, busy2, done2, irq2}), 32'h08);
    check("t1_rst_el", 32'(el2), 32'h000);
    tick(2);
    clr = 1'b1;
    tick(3);
    check("t1_idle_after", 32'({busy2, cten2, clrb2, done2}), 32'h2);

    // One-shot, PRESCALE 4, match 3.
    match_val = 12'd3;
    periodic = 1'b0;
    exp_irq(1'b0, cyc + 3*4 + 3, 12'd3);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("t2_clr_low", 32'({clrb4, busy4, cten4}), 32'h2);
    tick();
    check("t2_clr_high", 32'(clrb4), 32'd1);
    for (int k = 0; k < 13; k++) begin
      check("t2_cten", 32'(cten4), 32'(k % 4 == 3));
      check("t2_elapsed", 32'(el4), 32'(k / 4));
      tick();
    end
    check("t2_irq_done", 32'({irq4, done4, busy4}), 32'h6);
    for (int k = 0; k < 20; k++) begin
      check("t2_done_hold", 32'({done4, cten4, clrb4}), 32'h5);
      tick();
    end
    check("t2_el_hold", 32'(el4), 32'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t2_idle", 32'({busy4, done4}), 32'h0);

    // Periodic, PRESCALE 4, match 2: one irq and one clear every 10 cycles.
    match_val = 12'd2;
    periodic = 1'b1;
    for (int p = 0; p < 5; p++) exp_irq(1'b0, cyc + 11 + 10*p, 12'd2);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      if (!clrb4) lows++;
      tick();
    end
    check("t3_clear_count", 32'(lows), 32'd5);
    stop = 1'b1;
    periodic = 1'b0;
    tick();
    stop = 1'b0;
    check("t3_stopped", 32'({busy4, done4, cten4}), 32'h0);

    // Epoch carry, PRESCALE 2, match 0x013.
    match_val = 12'h013;
    exp_irq(1'b1, cyc + 12'h013*2 + 3, 12'h013);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 100 && el2 != 12'h00F; i++) tick();
    check("t4_reach_00f", 32'(el2), 32'h00F);
    tick();
    check("t4_tc_cycle", 32'({cten2, tc2}), 32'h3);
    tick();
    check("t4_carry", 32'(el2), 32'h010);
    for (int i = 0; i < 30 && !done2; i++) tick();
    check("t4_done", 32'(done2), 32'd1);
    check("t4_el_final", 32'(el2), 32'h013);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Pause at div=1, then stop colliding with a match.
    match_val = 12'd1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(2);
    check("t5_pre_pause", 32'({busy4, cten4}), 32'h2);
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t5_paused", 32'({cten4, busy4}), 32'h1);
      check("t5_frozen", 32'(el4), 32'd0);
    end
    pause = 1'b0;
    tick();
    check("t5_resume1", 32'(cten4), 32'd0);
    tick();
    check("t5_resume2", 32'(cten4), 32'd1);
    tick();
    check("t5_match_el", 32'(el4), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_stop_win", 32'({busy4, done4, irq4}), 32'h0);
    tick(3);
    check("t5_el_kept", 32'({busy4, el4}), 32'h001);

    // match_val 0: immediate match, no tick ever.
    match_val = 12'd0;
    exp_irq(1'b0, cyc + 3, 12'd0);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("t6_clear", 32'(clrb4), 32'd0);
    tick();
    check("t6_run", 32'({busy4, cten4}), 32'h2);
    check("t6_run_el", 32'(el4), 32'd0);
    tick();
    check("t6_done", 32'({done4, irq4}), 32'h3);
    for (int i = 0; i < 20; i++) begin
      check("t6_hold", 32'({done4, cten4}), 32'h2);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;

    tick(3);
    check("sb4_drained", 32'(q4.size()), 32'd0);
    check("sb2_drained", 32'(q2.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
